rsa_encryptor: RTL

Transmit-side RSA peer of the decryptor. Loads the public key (e, n) when the decryptor announces key generation done, then accepts 64-bit plaintext words and computes C = M^e mod n with an iterative square-and-multiply engine. The engine uses bit-serial interleaved modular multiplication, so there is no wide multiplier. Each finished ciphertext is presented with a one-cycle strobe that drives the decryptor's msg_received_sig input.

---
 rtl/rsa_encryptor.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/rsa_encryptor.sv
// RSA transmit side: holds the public key (e, n) and computes C = M^e mod n
// with square-and-multiply over a bit-serial interleaved modular multiplier.
module rsa_encryptor #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             key_valid,
  input  logic [WIDTH-1:0] e_in,
  input  logic [WIDTH-1:0] n_in,
  input  logic             msg_valid,
  input  logic [WIDTH-1:0] plaintext,
  output logic             msg_ready,
  output logic [WIDTH-1:0] encrypted_message,
  output logic             msg_sent_sig,
  output logic             busy,
  output logic             key_loaded,
  output logic             key_error
);

  // Handshake: a message transfers on a cycle where msg_valid and msg_ready are
  // both high; msg_ready is high only in IDLE and the source holds msg_valid
  // (with stable plaintext) until that cycle.
  typedef enum logic [2:0] {NOKEY, IDLE, REDUCE, MUL, SQR, DONE} state_t;

  localparam int CW = $clog2(WIDTH);

  state_t           state;
  logic [WIDTH-1:0] e_key, n_key, pend_e, pend_n;
  logic             pend;
  logic [WIDTH-1:0] exp_w, base, result;
  logic [WIDTH-1:0] mm_a, mm_b, mm_r;
  logic [CW-1:0]    mm_cnt;

  logic             key_ok;
  logic             mm_last;
  logic [WIDTH-1:0] exp_shift;
  logic [WIDTH:0]   n_ext, dbl, dbl_red, sum;
  logic [WIDTH-1:0] mm_next;

  assign key_ok    = key_valid && (n_in >= WIDTH'(2));
  assign mm_last   = (mm_cnt == CW'(WIDTH - 1));
  assign exp_shift = exp_w >> 1;

  // One step of r = a*b mod n, consuming b from its MSB; r stays below n.
  assign n_ext   = {1'b0, n_key};
  assign dbl     = {mm_r, 1'b0};
  assign dbl_red = (dbl >= n_ext) ? dbl - n_ext : dbl;
  assign sum     = dbl_red + (mm_b[WIDTH-1] ? {1'b0, mm_a} : '0);
  assign mm_next = WIDTH'((sum >= n_ext) ? sum - n_ext : sum);

  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= NOKEY;
      e_key             <= '0;
      n_key             <= '0;
      pend_e            <= '0;
      pend_n            <= '0;
      pend              <= 1'b0;
      exp_w             <= '0;
      base              <= '0;
      result            <= '0;
      mm_a              <= '0;
      mm_b              <= '0;
      mm_r              <= '0;
      mm_cnt            <= '0;
      msg_ready         <= 1'b0;
      encrypted_message <= '0;
      msg_sent_sig      <= 1'b0;
      busy              <= 1'b0;
      key_loaded        <= 1'b0;
      key_error         <= 1'b0;
    end else begin
      key_error    <= key_valid && !key_ok;
      msg_sent_sig <= 1'b0;
      case (state)
        NOKEY: begin
          if (key_ok) begin
            e_key      <= e_in;
            n_key      <= n_in;
            key_loaded <= 1'b1;
            msg_ready  <= 1'b1;
            state      <= IDLE;
          end
        end
        IDLE: begin
          if (msg_valid) begin
            exp_w     <= e_key;
            mm_a      <= WIDTH'(1);
            mm_b      <= plaintext;
            mm_r      <= '0;
            mm_cnt    <= '0;
            result    <= WIDTH'(1);
            busy      <= 1'b1;
            msg_ready <= 1'b0;
            state     <= REDUCE;
            // The accepted message keeps the old key; a simultaneous key waits.
            if (key_ok) begin
              pend   <= 1'b1;
              pend_e <= e_in;
              pend_n <= n_in;
            end
          end else if (key_ok) begin
            e_key <= e_in;
            n_key <= n_in;
          end
        end
        REDUCE, MUL, SQR: begin
          if (key_ok) begin
            pend   <= 1'b1;
            pend_e <= e_in;
            pend_n <= n_in;
          end
          mm_r   <= mm_next;
          mm_b   <= mm_b << 1;
          mm_cnt <= mm_cnt + 1'b1;
          if (mm_last) begin
            mm_r   <= '0;
            mm_cnt <= '0;
            if (state == MUL) begin
              result <= mm_next;
              exp_w  <= exp_shift;
              if (exp_shift != '0) begin
                mm_a  <= base;
                mm_b  <= base;
                state <= SQR;
              end else begin
                state <= DONE;
              end
            end else begin
              // REDUCE and SQR both produce a new base, then walk the exponent.
              base <= mm_next;
              if (exp_w == '0) begin
                state <= DONE;
              end else if (exp_w[0]) begin
                mm_a  <= result;
                mm_b  <= mm_next;
                state <= MUL;
              end else begin
                exp_w <= exp_shift;
                mm_a  <= mm_next;
                mm_b  <= mm_next;
                state <= SQR;
              end
            end
          end
        end
        DONE: begin
          encrypted_message <= result;
          msg_sent_sig      <= 1'b1;
          busy              <= 1'b0;
          msg_ready         <= 1'b1;
          state             <= IDLE;
          pend              <= 1'b0;
          if (key_ok) begin
            e_key <= e_in;
            n_key <= n_in;
          end else if (pend) begin
            e_key <= pend_e;
            n_key <= pend_n;
          end
        end
        default: state <= NOKEY;
      endcase
    end
  end

endmodule
